// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S FIFO reader.
package i2s_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    POLL = 3'b010,
    WAIT = 3'b100
  } i2s_fetch_state_t;

  localparam int unsigned I2S_DATA_DELAY = 1;
  localparam int unsigned UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: bclk toggles every BCLK_DIV clk cycles; fall marks the 1->0 cycle.
module i2s_bclk_gen #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall
);
  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  if (BCLK_DIV < 2) begin : g_bad_div
    $error("BCLK_DIV must be at least 2");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             wrap;

  always_comb begin
    wrap   = (div_q == DIV_W'(BCLK_DIV - 1));
    div_d  = wrap ? '0 : div_q + 1'b1;
    bclk_d = wrap ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;
  assign fall = wrap && bclk_q;

endmodule

// File: rtl/i2s_fifo_reader.sv
// I2S master draining {left,right} words from a standard FIFO, one word per frame.
// Optional build macro: I2S_UNDERRUN_CNT_EN adds the saturating underrun_count port.
module i2s_fifo_reader
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SLOT_BITS    = 32,
  parameter int unsigned BCLK_DIV     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fifo_rd_ready,
  output logic                      fifo_rd_en,
  input  logic [2*SAMPLE_WIDTH-1:0] fifo_rd_data,
  output logic                      i2s_bclk,
  output logic                      i2s_lrclk,
  output logic                      i2s_sd,
  output logic                      underrun
`ifdef I2S_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
`endif
);
  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned WORD_W     = 2 * SAMPLE_WIDTH;

  if (SLOT_BITS <= SAMPLE_WIDTH) begin : g_bad_slot
    $error("SLOT_BITS must exceed SAMPLE_WIDTH");
  end

  logic              fall;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] frame_q, frame_d, hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              started_q, started_d;
  logic              lrclk_q, lrclk_d, sd_q, sd_d, underrun_q, underrun_d;
  logic              frame_start, capture;
  i2s_fetch_state_t  state_q, state_d;

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .clk  (clk),
    .rst  (rst),
    .bclk (i2s_bclk),
    .fall (fall)
  );

  // Slot offset o carries sample bit SAMPLE_WIDTH-o for o in 1..SAMPLE_WIDTH, else 0.
  function automatic logic sel_bit(input logic [WORD_W-1:0] w, input logic [CNT_W-1:0] cnt);
    int unsigned       c, o, idx;
    logic              right;
    logic [WORD_W-1:0] sh;
    c     = 32'(cnt);
    right = (c >= SLOT_BITS);
    o     = right ? c - SLOT_BITS : c;
    if (o >= I2S_DATA_DELAY && o < SAMPLE_WIDTH + I2S_DATA_DELAY) begin
      idx = SAMPLE_WIDTH - 1 - (o - I2S_DATA_DELAY) + (right ? 0 : SAMPLE_WIDTH);
      sh  = w >> idx;
      return sh[0];
    end
    return 1'b0;
  endfunction

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    lrclk_d      = lrclk_q;
    sd_d         = sd_q;
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    started_d    = started_q;
    frame_d      = frame_q;
    fifo_rd_en   = 1'b0;

    if (fall) begin
      bit_cnt_d = (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + 1'b1;
      lrclk_d   = (32'(bit_cnt_d) >= SLOT_BITS);
      sd_d      = sel_bit(frame_q, bit_cnt_d);
    end
    frame_start = fall && (bit_cnt_d == '0);
    capture     = (state_q == WAIT);
    underrun_d  = frame_start && !hold_valid_q && !capture && started_q;

    unique case (state_q)
      IDLE: if (frame_start) state_d = POLL;
      POLL: begin
        fifo_rd_en = fifo_rd_ready && !rst;
        if (fifo_rd_en) state_d = WAIT;
      end
      WAIT: begin
        hold_d       = fifo_rd_data;
        hold_valid_d = 1'b1;
        started_d    = 1'b1;
        // A capture that coincides with frame start is consumed at once, so keep prefetching.
        state_d      = frame_start ? POLL : IDLE;
      end
      default: state_d = POLL;
    endcase

    if (frame_start) begin
      frame_d      = capture ? fifo_rd_data : (hold_valid_q ? hold_q : '0);
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= CNT_W'(FRAME_BITS - 1);
      lrclk_q      <= 1'b0;
      sd_q         <= 1'b0;
      underrun_q   <= 1'b0;
      state_q      <= POLL;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      started_q    <= 1'b0;
      frame_q      <= '0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      sd_q         <= sd_d;
      underrun_q   <= underrun_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      started_q    <= started_d;
      frame_q      <= frame_d;
    end
  end

  assign i2s_lrclk = lrclk_q;
  assign i2s_sd    = sd_q;
  assign underrun  = underrun_q;

`ifdef I2S_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] ucnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ucnt_q <= '0;
    end else if (underrun_d && (ucnt_q != '1)) begin
      ucnt_q <= ucnt_q + 1'b1;
    end
  end

  assign underrun_count = ucnt_q;
`endif

endmodule
